fetch_unit: RTL and testbench

//  IF-stage front end. Owns the PC register and the instruction-memory request/response

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/if_id_reg.sv | 54 +++++
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch front end: the fetch FSM
// state type and the default reset PC / bubble instruction used by
// fetch_unit and by the reusable IF/ID-style pipeline register.
// ---------------------------------------------------------------------------
package fetch_pkg;

  // Fetch FSM states: idle after reset, request issue, waiting for the
  // memory response, and holding a fetched instruction during a stall.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0 -- the canonical bubble instruction
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // PC loaded when the core comes out of reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// Pipeline register holding {PC, instruction, valid} between two stages.
// Priority: flush (insert bubble) > stall (hold) > load valid entry >
// bubble. The PC is left untouched whenever a bubble is inserted, since a
// bubble carries no meaningful PC.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   flush               kill the stage contents (bubble)
//   stall               freeze the stage contents
//   load_valid          upstream presents a valid instruction
//   load_pc, load_inst  upstream PC and instruction
//   pc, inst, valid     registered stage contents
// ---------------------------------------------------------------------------
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        stall,
  input  logic        load_valid,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        valid
);

  // Register update with flush overriding stall; anything that is neither
  // a stall nor a valid load becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= 32'h0000_0000;
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (flush) begin
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (!stall) begin
      if (load_valid) begin
        pc    <= load_pc;
        inst  <= load_inst;
        valid <= 1'b1;
      end else begin
        inst  <= NOP_INST;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// IF-stage front end. Owns the PC, runs the single-outstanding instruction
// memory request/response handshake, presents the fetched instruction and
// its PC to branch prediction, and drives the IF/ID register into decode.
// Memory latency may vary; responses belonging to a request that was
// overtaken by a flush are discarded through the drop flag.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_next_PC, i_flush             next PC / redirect from branch prediction
//   i_stall                        hazard stall from decode
//   o_PC_IF, o_inst_IF, o_valid_IF instruction currently in IF
//   o_PC_ID, o_inst_ID, o_valid_ID IF/ID pipeline register
//   o_imem_req, o_imem_addr        fetch request (held until i_imem_gnt)
//   i_imem_gnt                     request accepted
//   i_imem_rvalid, i_imem_rdata    in-order response, one per grant
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_next_PC,
  input  logic        i_flush,
  input  logic        i_stall,
  output logic [31:0] o_PC_IF,
  output logic [31:0] o_inst_IF,
  output logic        o_valid_IF,
  output logic [31:0] o_PC_ID,
  output logic [31:0] o_inst_ID,
  output logic        o_valid_ID,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pc_if;
  logic         drop;
  logic         drop_next;
  logic [31:0]  hold_buf;
  logic [31:0]  hold_buf_next;
  logic         valid_if;
  logic [31:0]  inst_if;
  logic         imem_req;

  // FSM state, stale-response flag and stall holding buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      drop     <= 1'b0;
      hold_buf <= NOP_INST;
    end else begin
      state    <= state_next;
      drop     <= drop_next;
      hold_buf <= hold_buf_next;
    end
  end

  // Next-state and IF-stage outputs. A flush always steers back to S_REQ,
  // except when a request is still waiting for its grant: then the same
  // request simply retargets to the new PC. If a request is already in
  // flight when the flush hits, drop marks its response as stale. Any
  // response clears drop, because with a single outstanding request that
  // response is the one drop was guarding against.
  always_comb begin
    state_next    = state;
    drop_next     = drop;
    hold_buf_next = hold_buf;
    imem_req      = 1'b0;
    valid_if      = 1'b0;
    inst_if       = i_imem_rdata;
    case (state)
      S_IDLE: begin
        state_next = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (i_imem_gnt) begin
          state_next = S_WAIT;
          if (i_flush) begin
            drop_next = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          drop_next = 1'b0;
          valid_if  = !drop;
          if (i_flush || drop || !i_stall) begin
            state_next = S_REQ;
          end else begin
            hold_buf_next = i_imem_rdata;
            state_next    = S_HOLD;
          end
        end else if (i_flush) begin
          drop_next = 1'b1;
        end
      end
      S_HOLD: begin
        valid_if = 1'b1;
        inst_if  = hold_buf;
        if (i_flush) begin
          hold_buf_next = NOP_INST;
          state_next    = S_REQ;
        end else if (!i_stall) begin
          state_next = S_REQ;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // The PC advances once the IF instruction is handed to decode, or
  // jumps immediately on a redirect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_if <= RESET_PC;
    end else if ((valid_if && !i_stall) || i_flush) begin
      pc_if <= i_next_PC;
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .flush      (i_flush),
    .stall      (i_stall),
    .load_valid (valid_if),
    .load_pc    (pc_if),
    .load_inst  (inst_if),
    .pc         (o_PC_ID),
    .inst       (o_inst_ID),
    .valid      (o_valid_ID)
  );

  assign o_PC_IF     = pc_if;
  assign o_inst_IF   = inst_if;
  assign o_valid_IF  = valid_if;
  assign o_imem_req  = imem_req;
  assign o_imem_addr = pc_if;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Randomized self-checking bench for fetch_unit. A behavioural memory
// (one outstanding request, random grant and latency) answers fetches with
// an address-dependent word. The reference model tracks fetches by flush
// epoch: a response is usable only if no flush happened since its request
// was granted. It also keeps the fetched-but-unconsumed instruction, the
// expected PC stream and the expected IF/ID contents.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        flush;
  logic        stall;
  logic [31:0] o_PC_IF;
  logic [31:0] o_inst_IF;
  logic        o_valid_IF;
  logic [31:0] o_PC_ID;
  logic [31:0] o_inst_ID;
  logic        o_valid_ID;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_next_PC     (next_pc),
    .i_flush       (flush),
    .i_stall       (stall),
    .o_PC_IF       (o_PC_IF),
    .o_inst_IF     (o_inst_IF),
    .o_valid_IF    (o_valid_IF),
    .o_PC_ID       (o_PC_ID),
    .o_inst_ID     (o_inst_ID),
    .o_valid_ID    (o_valid_ID),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (gnt),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (rdata)
  );

  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;

  // stimulus knobs (percentages and maximum memory latency)
  int p_gnt, p_stall, p_flush, p_jump, lat_max;

  // memory model
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_epoch;
  int          mem_lat;
  bit          late_rsp;

  // reference model
  logic [31:0] mpc;
  int          epoch;
  bit          slot_full;
  logic [31:0] slot_inst;
  logic [31:0] exp_pc_id;
  logic [31:0] exp_inst_id;
  bit          exp_valid_id;
  bit          started;
  int          vid_seen;
  int          deliveries;

  // Distinct word per address (odd multiplier is a bijection mod 2^32).
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return ((addr ^ 32'hA5A5_0000) * 32'h9E37_79B1) + 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic configure(input int g, input int lat, input int st, input int fl, input int jp);
    p_gnt = g; lat_max = lat; p_stall = st; p_flush = fl; p_jump = jp;
  endtask

  task automatic resetModel();
    mpc          = RESET_PC;
    epoch        = 0;
    slot_full    = 0;
    slot_inst    = NOP;
    exp_pc_id    = 32'h0;
    exp_inst_id  = NOP;
    exp_valid_id = 0;
    mem_busy     = 0;
    mem_lat      = 0;
    started      = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check the DUT
  // against the model, then advance the model across the rising edge.
  task automatic applyStimulus();
    bit          good_rsp;
    bit          mem_rsp;
    bit          vif_exp;
    bit          req_seen;
    logic [31:0] inst_exp;
    logic [31:0] addr_seen;
    logic [31:0] target;
    @(negedge clk);
    rvalid   = 1'b0;
    rdata    = $urandom;
    good_rsp = 0;
    mem_rsp  = 0;
    if (late_rsp) begin
      rvalid   = 1'b1;
      late_rsp = 0;
    end else if (mem_busy && mem_lat == 0) begin
      rvalid   = 1'b1;
      rdata    = mem_word(mem_addr);
      mem_rsp  = 1;
      good_rsp = (mem_epoch == epoch);
    end
    gnt    = o_imem_req && ($urandom_range(99) < p_gnt);
    stall  = ($urandom_range(99) < p_stall);
    flush  = ($urandom_range(99) < p_flush);
    target = $urandom & 32'hFFFF_FFFC;
    if (flush || ($urandom_range(99) < p_jump)) next_pc = target;
    else next_pc = mpc + 32'd4;
    #1;
    vif_exp  = slot_full || good_rsp;
    inst_exp = slot_full ? slot_inst : rdata;
    checkOutput("imem_req", 32'(o_imem_req), 32'(started && !mem_busy && !slot_full));
    checkOutput("imem_addr", o_imem_addr, mpc);
    checkOutput("PC_IF", o_PC_IF, mpc);
    checkOutput("valid_IF", 32'(o_valid_IF), 32'(vif_exp));
    if (vif_exp) checkOutput("inst_IF", o_inst_IF, inst_exp);
    checkOutput("valid_ID", 32'(o_valid_ID), 32'(exp_valid_id));
    checkOutput("inst_ID", o_inst_ID, exp_inst_id);
    if (exp_valid_id) checkOutput("PC_ID", o_PC_ID, exp_pc_id);
    if (o_valid_ID) vid_seen++;
    req_seen  = o_imem_req;
    addr_seen = o_imem_addr;
    @(posedge clk);
    if (mem_rsp) mem_busy = 0;
    else if (mem_busy) mem_lat--;
    if (req_seen && gnt) begin
      mem_busy  = 1;
      mem_addr  = addr_seen;
      mem_epoch = epoch;
      mem_lat   = $urandom_range(lat_max - 1, 0);
    end
    if (flush) begin
      exp_valid_id = 0;
      exp_inst_id  = NOP;
      mpc          = next_pc;
      slot_full    = 0;
      epoch++;
    end else if (stall) begin
      if (good_rsp) begin
        slot_full = 1;
        slot_inst = rdata;
      end
    end else if (vif_exp) begin
      exp_valid_id = 1;
      exp_pc_id    = mpc;
      exp_inst_id  = inst_exp;
      mpc          = next_pc;
      slot_full    = 0;
      deliveries++;
    end else begin
      exp_valid_id = 0;
      exp_inst_id  = NOP;
    end
    started = 1;
  endtask

  // Assert reset asynchronously a little after a rising edge and release
  // it just after a later rising edge so the first checked cycle is S_IDLE.
  task automatic doReset(input bit with_late_rsp);
    #2;
    rst_n  = 1'b0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    flush  = 1'b0;
    stall  = 1'b0;
    #1;
    resetModel();
    checkOutput("rst_PC_IF", o_PC_IF, RESET_PC);
    checkOutput("rst_valid_IF", 32'(o_valid_IF), 32'h0);
    checkOutput("rst_imem_req", 32'(o_imem_req), 32'h0);
    checkOutput("rst_valid_ID", 32'(o_valid_ID), 32'h0);
    checkOutput("rst_inst_ID", o_inst_ID, NOP);
    checkOutput("rst_PC_ID", o_PC_ID, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n    = 1'b1;
    late_rsp = with_late_rsp;
  endtask

  initial begin
    int          v0;
    logic [31:0] a0;
    rst_n      = 1'b0;
    next_pc    = 32'h0;
    flush      = 1'b0;
    stall      = 1'b0;
    gnt        = 1'b0;
    rvalid     = 1'b0;
    rdata      = 32'h0;
    late_rsp   = 0;
    vid_seen   = 0;
    deliveries = 0;
    configure(100, 1, 0, 0, 0);
    @(posedge clk);
    doReset(0);

    // 1-cycle memory, sequential PCs: one instruction every second cycle
    repeat (4) applyStimulus();
    v0 = vid_seen;
    repeat (20) applyStimulus();
    checkOutput("throughput", 32'(vid_seen - v0), 32'd10);

    // heavy stalls with a fast memory
    configure(100, 1, 50, 0, 10);
    repeat (300) applyStimulus();

    // everything random: grant delays, latency up to 4, stalls, flushes
    configure(60, 4, 30, 10, 10);
    repeat (1500) applyStimulus();

    // grant withheld: request and address must sit still
    configure(0, 1, 0, 0, 0);
    repeat (8) applyStimulus();
    a0 = o_imem_addr;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("gnt_low_req", 32'(o_imem_req), 32'h1);
      checkOutput("gnt_low_addr", o_imem_addr, a0);
    end

    // async reset while a response is outstanding, late response ignored
    configure(100, 4, 0, 0, 0);
    begin
      int guard = 0;
      while (!(mem_busy && mem_lat > 0) && guard < 50) begin
        applyStimulus();
        guard++;
      end
      checkOutput("reach_wait", 32'(guard < 50), 32'h1);
    end
    doReset(1);
    repeat (6) applyStimulus();

    configure(70, 3, 25, 8, 5);
    repeat (500) applyStimulus();

    checkOutput("progress", 32'(deliveries > 100), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
